instr_mem_loader: RTL

Boot-time program loader that sits directly upstream of the single-cycle MIPS core and its instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into the instruction memory through a dedicated write port. The loader holds the core in reset until the requested number of words has been stored, then releases it.

---
 rtl/instr_mem_loader_if.sv | 36 +++
 rtl/instr_mem_loader.sv | 118 +++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream, instruction-memory write port and core-control bundle for the
// boot-time program loader. The loader drives through the master modport; the
// byte source, memory and core sit on the slave side.
interface instr_mem_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7
);
  // Load control
  logic              Start;
  logic [ADDR_W-1:0] Word_Count;

  // Byte stream handshake
  logic [7:0]        Byte_In;
  logic              Byte_Valid;
  logic              Byte_Ready;

  // Instruction memory write port
  logic              IM_WE;
  logic [ADDR_W-1:0] IM_Addr;
  logic [WIDTH-1:0]  IM_WD;

  // Core control and status
  logic              Core_RST;
  logic              Busy;
  logic              Done;

  modport master (
    input  Start, Word_Count, Byte_In, Byte_Valid,
    output Byte_Ready, IM_WE, IM_Addr, IM_WD, Core_RST, Busy, Done
  );

  modport slave (
    output Start, Word_Count, Byte_In, Byte_Valid,
    input  Byte_Ready, IM_WE, IM_Addr, IM_WD, Core_RST, Busy, Done
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time program loader. Collects a little-endian byte stream into 32-bit
// instruction words, writes each word into instruction memory, and keeps the
// MIPS core in reset until the requested number of words has been stored.
// WIDTH must be 32 and 2**ADDR_W must be at least DEPTH.
module instr_mem_loader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7
) (
  input  logic                CLK,
  input  logic                RST,
  instr_mem_loader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_t;

  // Highest legal word address, and DEPTH widened by one bit so it can be
  // compared against Word_Count even when DEPTH equals 2**ADDR_W.
  localparam logic [ADDR_W-1:0] LAST_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t             state;
  logic [1:0]         byte_idx;
  logic [ADDR_W-1:0]  word_idx;
  logic [ADDR_W-1:0]  last_idx;
  logic [WIDTH-9:0]   word_buf;

  // The loader keeps the index of the last word rather than the count itself,
  // so a full-depth load never needs a value wider than ADDR_W bits.
  function automatic logic [ADDR_W-1:0] clamp_last(input logic [ADDR_W-1:0] n);
    if (n == '0 || {1'b0, n} > DEPTH_EXT)
      return LAST_MAX;
    else
      return n - ADDR_W'(1);
  endfunction

  // Single state machine that also owns the byte buffer, the write port and
  // the registered status outputs, so every output changes only with state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      byte_idx       <= '0;
      word_idx       <= '0;
      last_idx       <= '0;
      word_buf       <= '0;
      bus.IM_WE      <= 1'b0;
      bus.IM_Addr    <= '0;
      bus.IM_WD      <= '0;
      bus.Byte_Ready <= 1'b0;
      bus.Busy       <= 1'b0;
      bus.Done       <= 1'b0;
      bus.Core_RST   <= 1'b1;
    end else begin
      bus.IM_WE <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            last_idx       <= clamp_last(bus.Word_Count);
            word_idx       <= '0;
            byte_idx       <= '0;
            bus.Byte_Ready <= 1'b1;
            bus.Busy       <= 1'b1;
            state          <= LOAD;
          end
        end

        LOAD: begin
          if (bus.Byte_Valid && bus.Byte_Ready) begin
            if (byte_idx == 2'd3) begin
              // The fourth byte goes straight to the write port together
              // with the three buffered ones.
              bus.IM_WD      <= {bus.Byte_In, word_buf};
              bus.IM_Addr    <= word_idx;
              bus.IM_WE      <= 1'b1;
              bus.Byte_Ready <= 1'b0;
              byte_idx       <= '0;
              state          <= WRITE;
            end else begin
              case (byte_idx)
                2'd0:    word_buf[7:0]   <= bus.Byte_In;
                2'd1:    word_buf[15:8]  <= bus.Byte_In;
                default: word_buf[23:16] <= bus.Byte_In;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        WRITE: begin
          if (word_idx == last_idx) begin
            bus.Busy     <= 1'b0;
            bus.Done     <= 1'b1;
            bus.Core_RST <= 1'b0;
            state        <= RUN;
          end else begin
            word_idx       <= word_idx + ADDR_W'(1);
            bus.Byte_Ready <= 1'b1;
            state          <= LOAD;
          end
        end

        RUN: begin
          state <= RUN;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
